// File: rtl/soc_hash_pkg.sv
// soc_hash_pkg: shared state encoding and width helper for the hash bridge.
package soc_hash_pkg;

    // Bridge control states.
    typedef enum logic [1:0] {
        StLoad,
        StStart,
        StWait,
        StOut
    } bridge_state_e;

    // Bits needed to hold values 0..n-1; never less than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hash_word_serializer.sv
// hash_word_serializer: parallel-loads an L-bit digest and streams it out
// MSB-first as DW-bit words over a valid/ready handshake with a last flag.
module hash_word_serializer
    import soc_hash_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned L  = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [L-1:0]  load_data,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          last,
    input  logic          ready
);
    localparam int unsigned NumWords = L / DW;
    localparam int unsigned IdxW     = width_of(NumWords);

    logic [L-1:0]    shreg_q;
    logic [IdxW-1:0] idx_q;
    logic            valid_q;
    logic            at_last;

    assign at_last = (idx_q == IdxW'(NumWords - 1));

    // Load the digest, then shift one word out per accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shreg_q <= load_data;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q && ready) begin
            if (at_last) begin
                shreg_q <= '0;
                idx_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                shreg_q <= shreg_q << DW;
                idx_q   <= idx_q + IdxW'(1);
            end
        end
    end

    assign valid = valid_q;
    assign data  = shreg_q[L-1 -: DW];
    assign last  = valid_q && at_last;

endmodule

// File: rtl/soc_hash_bridge.sv
// soc_hash_bridge: collects a message from an input word stream, hands it to
// a hash core with a start pulse, then streams the returned digest out.
// Optional core watchdog: define SOC_HASH_BRIDGE_TIMEOUT_EN.
module soc_hash_bridge
    import soc_hash_pkg::*;
#(
    parameter int unsigned DW          = 8,
    parameter int unsigned MSG_MAX     = 128,
    parameter int unsigned L           = 256,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_validxSI,
    input  logic [DW-1:0]                in_dataxDI,
    input  logic                         in_lastxSI,
    output logic                         in_readyxSO,
    output logic [MSG_MAX-1:0]           core_messagexDO,
    output logic [$clog2(MSG_MAX+1)-1:0] core_lenxDO,
    output logic                         core_startxSO,
    input  logic                         core_readyxSI,
    input  logic [L-1:0]                 core_digestxDI,
    output logic                         out_validxSO,
    output logic [DW-1:0]                out_dataxDO,
    output logic                         out_lastxSO,
    input  logic                         out_readyxSI,
    output logic                         busyxSO,
    output logic                         errxSO
);
    localparam int unsigned NumWords = MSG_MAX / DW;
    localparam int unsigned CntW     = width_of(NumWords + 1);
    localparam int unsigned LenW     = $clog2(MSG_MAX + 1);
    localparam int unsigned MsgIdxW  = width_of(MSG_MAX);

    bridge_state_e      state_q;
    logic [MSG_MAX-1:0] msg_q;
    logic [CntW-1:0]    cnt_q;
    logic               in_ready_q;
    logic               start_q;
    logic               busy_q;
    logic               accept;
    logic               digest_load;
    logic               out_done;
    logic               wd_expire;
    logic [MsgIdxW-1:0] wr_msb;

    assign accept      = in_validxSI && in_ready_q;
    assign digest_load = (state_q == StWait) && core_readyxSI;
    assign out_done    = out_validxSO && out_readyxSI && out_lastxSO;
    // Word k lands k words below the MSB end of the buffer.
    assign wr_msb      = MsgIdxW'(MSG_MAX - 1 - 32'(cnt_q) * DW);

`ifdef SOC_HASH_BRIDGE_TIMEOUT_EN
    localparam int unsigned WdW = width_of(TIMEOUT_CYC);

    logic [WdW-1:0] wd_q;
    logic           err_q;

    assign wd_expire = (state_q == StWait) && !core_readyxSI &&
                       (wd_q == WdW'(TIMEOUT_CYC - 1));

    // Count consecutive WAIT cycles; restart whenever WAIT is left.
    always_ff @(posedge clk) begin
        if (!rst || state_q != StWait) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WdW'(1);
        end
    end

    // Sticky error: set on expiry, cleared by the next accepted word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (wd_expire) begin
            err_q <= 1'b1;
        end else if (accept) begin
            err_q <= 1'b0;
        end
    end

    assign errxSO = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYC;
    assign wd_expire      = 1'b0;
    assign errxSO         = 1'b0;
`endif

    // Control FSM: gather words, pulse start, await the core, drain the digest.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StLoad;
            msg_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (accept) begin
                        msg_q[wr_msb -: DW] <= in_dataxDI;
                        cnt_q               <= cnt_q + CntW'(1);
                        // A full buffer ends the message even without last.
                        if (in_lastxSI || (cnt_q == CntW'(NumWords - 1))) begin
                            state_q    <= StStart;
                            in_ready_q <= 1'b0;
                            start_q    <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                StStart: begin
                    state_q <= StWait;
                    start_q <= 1'b0;
                end
                StWait: begin
                    if (digest_load) begin
                        state_q <= StOut;
                    end else if (wd_expire) begin
                        state_q    <= StLoad;
                        msg_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                StOut: begin
                    if (out_done) begin
                        state_q    <= StLoad;
                        msg_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign in_readyxSO     = in_ready_q;
    assign core_startxSO   = start_q;
    assign busyxSO         = busy_q;
    assign core_messagexDO = msg_q;
    assign core_lenxDO     = LenW'(32'(cnt_q) * DW);

    hash_word_serializer #(
        .DW (DW),
        .L  (L)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (digest_load),
        .load_data (core_digestxDI),
        .valid     (out_validxSO),
        .data      (out_dataxDO),
        .last      (out_lastxSO),
        .ready     (out_readyxSI)
    );

endmodule

// File: tb/tb_soc_hash_bridge.sv
// tb_soc_hash_bridge: randomized and directed stimulus against a transaction
// model (expected message image, expected digest byte stream).
`timescale 1ns/1ps
module tb_soc_hash_bridge;
    localparam int unsigned DW      = 8;
    localparam int unsigned MSG_MAX = 128;
    localparam int unsigned L       = 256;
    localparam int unsigned TCYC    = 16;
    localparam int unsigned NB      = L / DW;
    localparam int unsigned NW      = MSG_MAX / DW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic           in_validxSI = 1'b0, in_lastxSI = 1'b0, in_readyxSO;
    logic [DW-1:0]  in_dataxDI = '0;
    logic [127:0]   core_messagexDO;
    logic [7:0]     core_lenxDO;
    logic           core_startxSO;
    logic           core_readyxSI = 1'b0;
    logic [L-1:0]   core_digestxDI = '0;
    logic           out_validxSO, out_lastxSO;
    logic           out_readyxSI = 1'b1;
    logic [DW-1:0]  out_dataxDO;
    logic           busyxSO, errxSO;

    // Second instance at DW=16 for the wide-word packing case.
    logic           b_in_valid = 1'b0, b_in_last = 1'b0, b_in_ready;
    logic [15:0]    b_in_data = '0;
    logic [127:0]   b_msg;
    logic [7:0]     b_len;
    logic           b_start;
    logic           b_core_ready = 1'b0;
    logic [L-1:0]   b_digest = '0;
    logic           b_out_valid, b_out_last, b_busy, b_err;
    logic           b_out_ready = 1'b1;
    logic [15:0]    b_out_data;

    soc_hash_bridge #(
        .DW(DW), .MSG_MAX(MSG_MAX), .L(L), .TIMEOUT_CYC(TCYC)
    ) dut (
        .clk(clk), .rst(rst),
        .in_validxSI(in_validxSI), .in_dataxDI(in_dataxDI), .in_lastxSI(in_lastxSI),
        .in_readyxSO(in_readyxSO),
        .core_messagexDO(core_messagexDO), .core_lenxDO(core_lenxDO),
        .core_startxSO(core_startxSO), .core_readyxSI(core_readyxSI),
        .core_digestxDI(core_digestxDI),
        .out_validxSO(out_validxSO), .out_dataxDO(out_dataxDO), .out_lastxSO(out_lastxSO),
        .out_readyxSI(out_readyxSI), .busyxSO(busyxSO), .errxSO(errxSO)
    );

    soc_hash_bridge #(
        .DW(16), .MSG_MAX(MSG_MAX), .L(L), .TIMEOUT_CYC(1024)
    ) dut16 (
        .clk(clk), .rst(rst),
        .in_validxSI(b_in_valid), .in_dataxDI(b_in_data), .in_lastxSI(b_in_last),
        .in_readyxSO(b_in_ready),
        .core_messagexDO(b_msg), .core_lenxDO(b_len),
        .core_startxSO(b_start), .core_readyxSI(b_core_ready),
        .core_digestxDI(b_digest),
        .out_validxSO(b_out_valid), .out_dataxDO(b_out_data), .out_lastxSO(b_out_last),
        .out_readyxSI(b_out_ready), .busyxSO(b_busy), .errxSO(b_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state.
    logic [127:0] cur_msg = '0;
    int           cur_cnt = 0;
    logic [127:0] exp_msg = '0;
    int           exp_len = 0;
    bit           msg_pending = 0;
    int           msgs_done = 0;
    int           start_count = 0;
    logic [L-1:0] dig_q[$];
    int           k = 0;
    int           ready_cyc = 0;
    bit           first_pending = 0;
    int           rmode = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [L-1:0] rand256();
        logic [L-1:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Present one word and hold it until the bridge takes it.
    task automatic send_word(input logic [DW-1:0] d, input bit last);
        int n;
        n = 0;
        in_validxSI = 1'b1;
        in_dataxDI  = d;
        in_lastxSI  = last;
        while (!in_readyxSO && n < 500) begin
            tick();
            n++;
        end
        if (!in_readyxSO) fail_now("send_word: in_ready got 0 required 1");
        tick();
        in_validxSI = 1'b0;
        in_lastxSI  = 1'b0;
        cur_msg = cur_msg | (128'(d) << (MSG_MAX - DW * (cur_cnt + 1)));
        cur_cnt++;
        if (last || cur_cnt == NW) begin
            exp_msg     = cur_msg;
            exp_len     = cur_cnt * DW;
            msg_pending = 1;
            msgs_done++;
            cur_msg     = '0;
            cur_cnt     = 0;
        end
    endtask

    // Core side: optionally a spurious ready during START, then the real one.
    task automatic respond(input bit in_start, input int delay, input logic [L-1:0] d);
        if (in_start) begin
            core_readyxSI  = 1'b1;
            core_digestxDI = ~d;
            tick();
            core_readyxSI  = 1'b0;
            core_digestxDI = '0;
        end
        repeat (delay) tick();
        core_readyxSI  = 1'b1;
        core_digestxDI = d;
        dig_q.push_back(d);
        ready_cyc     = cyc;
        first_pending = 1;
        tick();
        core_readyxSI = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!in_readyxSO && n < 3000) begin
            tick();
            n++;
        end
        if (!in_readyxSO) fail_now({name, " drain: in_ready got 0 required 1"});
        check({name, "_all_bytes_out"}, dig_q.size(), 0);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_in_ready"}, in_readyxSO, 1);
        check({name, "_out_valid"}, out_validxSO, 0);
        check({name, "_out_data"}, out_dataxDO, 0);
        check({name, "_out_last"}, out_lastxSO, 0);
        check({name, "_start"}, core_startxSO, 0);
        check({name, "_msg"}, core_messagexDO, 0);
        check({name, "_len"}, core_lenxDO, 0);
        check({name, "_busy"}, busyxSO, 0);
        check({name, "_err"}, errxSO, 0);
    endtask

    // Consumer ready: 0 always ready, 1 random, 2 repeating 1,0,0,1.
    initial begin : ready_drv
        int p;
        p = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: out_readyxSI = 1'($urandom_range(0, 1));
                2: begin
                    out_readyxSI = (p % 4 == 0) || (p % 4 == 3);
                    p++;
                end
                default: out_readyxSI = 1'b1;
            endcase
        end
    end

    // Compare DUT against the transaction model once per cycle.
    initial begin : compare
        bit           stall;
        logic [L-1:0] cur;
        logic [DW-1:0] eb;
        stall = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall = 0;
                k = 0;
                dig_q.delete();
                msg_pending = 0;
                first_pending = 0;
                continue;
            end
            if (core_startxSO) begin
                if (!msg_pending) fail_now("spurious_start: core_start got 1 required 0");
                else begin
                    check("start_msg", core_messagexDO, exp_msg);
                    check("start_len", core_lenxDO, exp_len);
                end
                msg_pending = 0;
                start_count++;
            end
            if (stall) check("stall_hold_valid", out_validxSO, 1);
            stall = 0;
            if (out_validxSO) begin
                if (dig_q.size() == 0) begin
                    fail_now($sformatf("spurious_out: out_valid got 1 data %0h required 0",
                                       out_dataxDO));
                end else begin
                    cur = dig_q[0];
                    eb  = DW'(cur >> (DW * (NB - 1 - k)));
                    if (first_pending) begin
                        check("valid_latency", cyc, ready_cyc + 1);
                        first_pending = 0;
                    end
                    check("out_data", out_dataxDO, eb);
                    check("out_last", out_lastxSO, k == NB - 1);
                    if (out_readyxSI) begin
                        k++;
                        if (k == NB) begin
                            void'(dig_q.pop_front());
                            k = 0;
                        end
                    end else begin
                        stall = 1;
                    end
                end
            end else if (first_pending && cyc >= ready_cyc + 1) begin
                fail_now("valid_latency: out_valid got 0 required 1");
                first_pending = 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout: simulation still running");
        $fatal(1);
    end

    initial begin : driver
        logic [L-1:0]   d;
        logic [127:0]   lit;
        logic [15:0]    w16 [3];
        int             n;
        bit             lastf;

        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b1;
        tick();

        // 16 words 0x00..0x0F, last on word 15.
        for (int i = 0; i < 16; i++) send_word(DW'(i), i == 15);
        lit = 128'h000102030405060708090A0B0C0D0E0F;
        check("t1_msg", core_messagexDO, lit);
        check("t1_len", core_lenxDO, 128);
        check("t1_start", core_startxSO, 1);
        check("t1_busy", busyxSO, 1);
        d = 256'hF0E1D2C3B4A5968778695A4B3C2D1E0F00112233445566778899AABBCCDDEEFF;
        respond(1, 5, d);
        check("t1_first_valid", out_validxSO, 1);
        check("t1_first_byte", out_dataxDO, 8'hF0);
        wait_idle("t1");

        // Buffer full with last never asserted.
        for (int i = 0; i < 16; i++) send_word(DW'(8'hA0 + i), 1'b0);
        check("full_start", core_startxSO, 1);
        check("full_len", core_lenxDO, 128);
        respond(1, 2, rand256());
        wait_idle("full");

        // Single-word message, stalls 1,0,0,1 on the output.
        rmode = 2;
        send_word(8'h3C, 1'b1);
        lit = 128'h3C000000000000000000000000000000;
        check("one_msg", core_messagexDO, lit);
        check("one_len", core_lenxDO, 8);
        respond(1, 0, rand256());
        wait_idle("stall");

        // Randomized messages.
        for (int t = 0; t < 8; t++) begin
            rmode = 1;
            n     = $urandom_range(1, 16);
            lastf = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) send_word(DW'($urandom), (i == n - 1) && lastf);
            respond(1, $urandom_range(0, 8), rand256());
            wait_idle("rand");
        end
        rmode = 0;

`ifdef SOC_HASH_BRIDGE_TIMEOUT_EN
        // Core never answers: watchdog fires after TCYC WAIT cycles.
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b1);
        repeat (TCYC) tick();
        check("wd_err_before", errxSO, 0);
        check("wd_busy_before", busyxSO, 1);
        tick();
        check("wd_err_set", errxSO, 1);
        check("wd_in_ready", in_readyxSO, 1);
        check("wd_busy_clear", busyxSO, 0);
        repeat (3) tick();
        check("wd_err_sticky", errxSO, 1);
        send_word(8'h5A, 1'b0);
        check("wd_err_cleared", errxSO, 0);
        send_word(8'h5B, 1'b1);
        respond(1, 3, rand256());
        wait_idle("wd_after");
`else
        // Without the watchdog the bridge waits indefinitely.
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b1);
        repeat (60) tick();
        check("nowd_busy", busyxSO, 1);
        check("nowd_err", errxSO, 0);
        respond(0, 0, rand256());
        wait_idle("nowd");
`endif

        // Reset in the middle of the digest readout after three bytes.
        for (int i = 0; i < 4; i++) send_word(DW'($urandom), i == 3);
        respond(1, 2, rand256());
        n = 0;
        while (k < 3 && n < 100) begin
            tick();
            n++;
        end
        check("rst_three_bytes", k, 3);
        rst = 1'b0;
        tick();
        check_reset_state("rst_in");
        tick();
        rst = 1'b1;
        tick();
        check_reset_state("rst_after");
        repeat (40) tick();
        check("rst_no_more_out", out_validxSO, 0);

        // DW=16: three words, last on the third.
        w16[0] = 16'hAAAA;
        w16[1] = 16'hBBBB;
        w16[2] = 16'hCCCC;
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = w16[i];
            b_in_last  = (i == 2);
            n = 0;
            while (!b_in_ready && n < 50) begin
                tick();
                n++;
            end
            tick();
        end
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        lit = {48'hAAAABBBBCCCC, 80'h0};
        check("w16_start", b_start, 1);
        check("w16_msg", b_msg, lit);
        check("w16_len", b_len, 48);
        tick();
        check("w16_start_once", b_start, 0);

        check("start_count", start_count, msgs_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_hash_bridge.md
SOC_HASH_BRIDGE -- requirements
Module: soc_hash_bridge

Interface
REQ-001 SHALL have parameter DW, default 8: bus word width; legal values 8, 16, 32.
REQ-002 SHALL have parameter MSG_MAX, default 128: message buffer size in bits; must be a multiple of DW.
REQ-003 SHALL have parameter L, default 256: digest length in bits; must be a multiple of DW.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024: core watchdog limit in cycles.
REQ-005 SHALL have one clock and a synchronous, active-low reset, with ports in this order:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
REQ-006 SHALL have the input-stream ports:
- in_validxSI  in  1  input word valid
- in_dataxDI  in  DW  message word
- in_lastxSI  in  1  final word of the message
- in_readyxSO  out  1  bridge accepts a word
REQ-007 SHALL have the core-side ports:
- core_messagexDO  out  MSG_MAX  packed message
- core_lenxDO  out  $clog2(MSG_MAX+1)  message length in bits
- core_startxSO  out  1  start pulse
- core_readyxSI  in  1  hash done
- core_digestxDI  in  L  digest from core
REQ-008 SHALL have the output-stream ports:
- out_validxSO  out  1  digest word valid
- out_dataxDO  out  DW  digest word
- out_lastxSO  out  1  final digest word
- out_readyxSI  in  1  consumer ready
REQ-009 SHALL have the status ports:
- busyxSO  out  1  any state other than LOAD
- errxSO  out  1  watchdog expired

Function
REQ-010 SHALL implement the FSM states LOAD, START, WAIT and OUT, and SHALL enter LOAD on reset.
REQ-011 SHALL drive in_readyxSO=1 only in LOAD, and SHALL accept a word when in_validxSI and in_readyxSO are both 1 at a rising clk edge.
REQ-012 SHALL pack accepted word k into core_messagexDO[MSG_MAX-1-k*DW -: DW], first word at the MSBs, and SHALL hold all unwritten bits at 0.
REQ-013 SHALL drive core_lenxDO equal to the number of accepted words times DW.
REQ-014 SHALL move LOAD->START on acceptance of a word with in_lastxSI=1, or of word MSG_MAX/DW (buffer full, treated as last regardless of in_lastxSI).
REQ-015 SHALL assert core_startxSO for exactly one cycle, in START, then enter WAIT.
REQ-016 SHALL ignore core_readyxSI in any state other than WAIT.
REQ-017 SHALL, in WAIT, when core_readyxSI=1, capture core_digestxDI on that edge and enter OUT; out_validxSO SHALL go to 1 on the following cycle.
REQ-018 SHALL, in OUT, present digest words MSB-first, advance one word per cycle with out_validxSO&out_readyxSI, and hold out_dataxDO stable while out_readyxSI=0.
REQ-019 SHALL assert out_lastxSO with word L/DW-1; after that word is transferred the bridge SHALL clear the buffer, length and word count and enter LOAD.
REQ-020 SHALL accept a minimum message of one word; a message is never empty.

Reset
REQ-021 SHALL, while rst=0 at a clk edge, enter LOAD, clear the buffer, digest register and all counters, and drive every output to 0 except in_readyxSO (1 after reset).
REQ-022 SHALL abort any in-flight operation on reset without emitting partial digest words.

Configuration
REQ-023 SHALL, with SOC_HASH_BRIDGE_TIMEOUT_EN defined, count cycles in WAIT and, when the count reaches TIMEOUT_CYC, set errxSO, discard the operation and enter LOAD with the buffer cleared.
REQ-024 SHALL hold errxSO sticky until the next accepted input word, then clear it on that edge.
REQ-025 SHALL, without SOC_HASH_BRIDGE_TIMEOUT_EN, contain no watchdog counter, tie errxSO to 0 and wait in WAIT indefinitely.

Structure
REQ-026 SHALL take its FSM state encoding and a clog2-based width helper from package soc_hash_pkg.
REQ-027 SHALL implement the digest readout as sub-module hash_word_serializer (L-bit parallel load, DW-bit valid/ready output with last flag).

Verification
REQ-028 SHALL verify: DW=8, 16 words 0x00..0x0F with last on word 15 -> core_messagexDO=0x000102...0F, core_lenxDO=128, one start pulse.
REQ-029 SHALL verify: DW=16, 3 words 0xAAAA,0xBBBB,0xCCCC with last -> core_messagexDO upper 48 bits = 0xAAAABBBBCCCC, rest 0, core_lenxDO=48.
REQ-030 SHALL verify: core_readyxSI=1 during START -> ignored; asserted 5 cycles into WAIT -> out_validxSO 1 cycle later, 32 bytes MSB-first (DW=8), out_lastxSO on byte 31.
REQ-031 SHALL verify: out_readyxSI toggled 1,0,0,1 -> out_dataxDO stable across stalls, no word duplicated or lost.
REQ-032 SHALL verify: with SOC_HASH_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=16 and core_readyxSI held 0 -> errxSO=1 after 16 WAIT cycles, state LOAD, errxSO clears on the next accepted word.
REQ-033 SHALL verify: rst=0 mid-OUT after 3 bytes -> all outputs 0 and in_readyxSO=1 the cycle after release, no further digest bytes.
